// File: rtl/led_cmd_sched.sv
// Round-robin scheduler sharing the LED controller's write/cmd port among N_REQ requesters.
// Optional auto-stop timeout is compiled in with `define LED_SCHED_TIMEOUT_EN.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting; arbitrates requests (or a pending timeout stop)
// ISSUE | one cycle: gnt pulse, write pulse if the command changes the LED
// HOLD  | forced quiet time after a forwarded command, HOLD_CYCLES long
module led_cmd_sched #(
    parameter int N_REQ          = 4,
    parameter int HOLD_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] req_cmd,
    output logic [N_REQ-1:0] gnt,
    output logic             write,
    output logic             cmd,
    output logic             busy,
    output logic             led_on
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);
    localparam logic [PW-1:0] PTR_LAST  = PW'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    ptr, ptr_nxt;
    logic [HW-1:0]    hold_cnt, hold_cnt_nxt;
    logic [N_REQ-1:0] gnt_nxt;
    logic             write_nxt, cmd_nxt, led_on_nxt;
    logic [PW-1:0]    win_idx;
    logic             win_found;
    logic             to_pending;
    int               cand;

    // Round-robin search starting at ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!win_found && req[cand[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        hold_cnt_nxt = hold_cnt;
        gnt_nxt      = '0;
        write_nxt    = 1'b0;
        cmd_nxt      = 1'b0;
        led_on_nxt   = led_on;
        case (state)
            IDLE: begin
                // A pending timeout stop outranks every requester and leaves ptr alone.
                if (to_pending) begin
                    state_nxt = ISSUE;
                    write_nxt = 1'b1;
                    cmd_nxt   = 1'b0;
                end else if (win_found) begin
                    state_nxt        = ISSUE;
                    gnt_nxt[win_idx] = 1'b1;
                    cmd_nxt          = req_cmd[win_idx];
                    write_nxt        = (req_cmd[win_idx] != led_on);
                    ptr_nxt          = (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;
                end
            end
            ISSUE: begin
                state_nxt = IDLE;
                if (write) begin
                    led_on_nxt = cmd;
                    if (HOLD_CYCLES > 0) begin
                        state_nxt    = HOLD;
                        hold_cnt_nxt = HOLD_LOAD;
                    end
                end
            end
            HOLD: begin
                hold_cnt_nxt = (hold_cnt != '0) ? hold_cnt - 1'b1 : '0;
                if (hold_cnt <= HW'(1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt    <= '0;
            write  <= 1'b0;
            cmd    <= 1'b0;
            busy   <= 1'b0;
            led_on <= 1'b0;
        end else begin
            gnt    <= gnt_nxt;
            write  <= write_nxt;
            cmd    <= cmd_nxt;
            busy   <= (state_nxt != IDLE);
            led_on <= led_on_nxt;
        end
    end

`ifdef LED_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] to_cnt;

    // Counts cycles with the LED on; saturates at the limit until a stop is forwarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (state == ISSUE && write && !cmd) begin
            to_cnt <= '0;
        end else if (led_on && to_cnt != TO_LIMIT) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign to_pending = led_on && (to_cnt == TO_LIMIT);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign to_pending     = 1'b0;
`endif

endmodule

// File: tb/tb_led_cmd_sched.sv
// Directed self-checking bench for led_cmd_sched (HOLD_CYCLES=8 instance plus a HOLD_CYCLES=0 instance).
module tb_led_cmd_sched;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] req = '0, req_cmd = '0, gnt;
    logic         write, cmd, busy, led_on;
    logic [N-1:0] req_z = '0, req_cmd_z = '0, gnt_z;
    logic         write_z, cmd_z, busy_z, led_on_z;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    led_cmd_sched #(.N_REQ(N), .HOLD_CYCLES(8), .TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .reset(reset), .req(req), .req_cmd(req_cmd), .gnt(gnt),
        .write(write), .cmd(cmd), .busy(busy), .led_on(led_on)
    );

    led_cmd_sched #(.N_REQ(N), .HOLD_CYCLES(0), .TIMEOUT_CYCLES(20)) dut0 (
        .clk(clk), .reset(reset), .req(req_z), .req_cmd(req_cmd_z), .gnt(gnt_z),
        .write(write_z), .cmd(cmd_z), .busy(busy_z), .led_on(led_on_z)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int nb;
        int ng;
        int g_time[3];
        logic [N-1:0] g_val[3];
        logic g_wr[3];
        int exp_t[3];
        logic [N-1:0] exp_g[3];
        int t_found;
        int n_wr;

        g_time = '{0, 0, 0};
        g_val  = '{4'b0000, 4'b0000, 4'b0000};
        g_wr   = '{1'b1, 1'b1, 1'b1};
        exp_t  = '{10, 12, 14};
        exp_g  = '{4'b0010, 4'b0100, 4'b1000};

        // reset values
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_write", 32'(write), 32'h0);
        chk("rst_cmd", 32'(cmd), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_led_on", 32'(led_on), 32'h0);
        reset = 1'b0;

        // start from requester 0, then 8 hold cycles
        req = 4'b0001; req_cmd = 4'b0001;
        tick();
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_write", 32'(write), 32'h1);
        chk("t1_cmd", 32'(cmd), 32'h1);
        chk("t1_busy", 32'(busy), 32'h1);
        req = '0;
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (busy) nb++;
        end
        chk("t1_hold_cycles", 32'(nb), 32'd8);
        chk("t1_led_on", 32'(led_on), 32'h1);
        chk("t1_idle_busy", 32'(busy), 32'h0);

        // redundant start from requester 2
        req = 4'b0100; req_cmd = 4'b0100;
        tick();
        chk("t2_gnt", 32'(gnt), 32'h4);
        chk("t2_write", 32'(write), 32'h0);
        chk("t2_busy", 32'(busy), 32'h1);
        req = '0;
        tick();
        chk("t2_busy_after", 32'(busy), 32'h0);
        chk("t2_led_on", 32'(led_on), 32'h1);

        // redundant start from requester 3 moves ptr back to 0
        req = 4'b1000; req_cmd = 4'b1000;
        tick();
        chk("t3_pre_gnt", 32'(gnt), 32'h8);
        req = '0;
        tick();

        // all four request stop with LED on
        req = 4'b1111; req_cmd = 4'b0000;
        tick();
        chk("t3_gnt0", 32'(gnt), 32'h1);
        chk("t3_write0", 32'(write), 32'h1);
        chk("t3_cmd0", 32'(cmd), 32'h0);
        req = req & ~gnt;
        ng = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (gnt != '0) begin
                if (ng < 3) begin
                    g_val[ng]  = gnt;
                    g_wr[ng]   = write;
                    g_time[ng] = i;
                end
                ng++;
                req = req & ~gnt;
            end
        end
        chk("t3_grant_count", 32'(ng), 32'd3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t3_gnt%0d", k + 1), 32'(g_val[k]), 32'(exp_g[k]));
            chk($sformatf("t3_write%0d", k + 1), 32'(g_wr[k]), 32'h0);
            chk($sformatf("t3_time%0d", k + 1), 32'(g_time[k]), 32'(exp_t[k]));
        end
        chk("t3_led_on", 32'(led_on), 32'h0);

        // zero-hold instance: alternating start/stop from requester 1
        req_z = 4'b0010; req_cmd_z = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t4_gnt%0d", k), 32'(gnt_z), 32'h2);
            chk($sformatf("t4_write%0d", k), 32'(write_z), 32'h1);
            chk($sformatf("t4_cmd%0d", k), 32'(cmd_z), (k % 2 == 0) ? 32'h1 : 32'h0);
            req_cmd_z[1] = ~req_cmd_z[1];
            tick();
            chk($sformatf("t4_gap%0d", k), 32'(write_z), 32'h0);
        end
        req_z = '0;
        tick();
        chk("t4_led_on", 32'(led_on_z), 32'h0);

        // reset during hold
        req = 4'b0010; req_cmd = 4'b0010;
        tick();
        chk("t5_gnt", 32'(gnt), 32'h2);
        chk("t5_write", 32'(write), 32'h1);
        req = '0;
        tick();
        tick();
        chk("t5_hold_busy", 32'(busy), 32'h1);
        chk("t5_hold_led", 32'(led_on), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_busy", 32'(busy), 32'h0);
        chk("t5_rst_led_on", 32'(led_on), 32'h0);
        chk("t5_rst_gnt", 32'(gnt), 32'h0);
        chk("t5_rst_write", 32'(write), 32'h0);
        tick();
        reset = 1'b0;
        req = 4'b1010; req_cmd = 4'b1010;
        tick();
        chk("t5_post_gnt", 32'(gnt), 32'h2);
        chk("t5_post_write", 32'(write), 32'h1);
        chk("t5_post_cmd", 32'(cmd), 32'h1);
        req = '0;

        // LED left on with no further requests
        t_found = 0;
        n_wr = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (write) begin
                n_wr++;
                if (t_found == 0) begin
                    t_found = i;
                    chk("t6_to_gnt", 32'(gnt), 32'h0);
                    chk("t6_to_cmd", 32'(cmd), 32'h0);
                end
            end
        end
`ifdef LED_SCHED_TIMEOUT_EN
        chk("t6_to_time", 32'(t_found), 32'd22);
        chk("t6_to_count", 32'(n_wr), 32'd1);
        chk("t6_led_on", 32'(led_on), 32'h0);
`else
        chk("t6_no_write", 32'(n_wr), 32'd0);
        chk("t6_led_on", 32'(led_on), 32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/led_cmd_sched.md
# led_cmd_sched

Command scheduler that sequences and shares the single-LED controller's `write`/`cmd` command port between `N_REQ` requesters. It arbitrates start/stop requests round-robin and forwards at most one command per arbitration slot as a one-cycle `write` pulse. It suppresses commands that would not change the LED state and enforces a minimum hold time after every forwarded command. It sits directly upstream of the LED controller, with its `write`/`cmd` outputs driving that controller's inputs.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `HOLD_CYCLES`, 8: idle cycles forced after each forwarded command, 0..255.
- `TIMEOUT_CYCLES`, 1000: auto-stop interval, ≥1; used only when the timeout feature is compiled in (see Configuration).
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  N_REQ  per-requester request; held high until granted.
- `req_cmd`  in  N_REQ  per-requester command, stable while `req` high: 1 = start (LED on), 0 = stop (LED off).
- `gnt`  out  N_REQ  one-hot grant, high for exactly one cycle.
- `write`  out  1  command strobe to the LED controller, one-cycle pulse.
- `cmd`  out  1  command to the LED controller; valid when `write`=1; 1 = start, 0 = stop.
- `busy`  out  1  high in ISSUE and HOLD.
- `led_on`  out  1  scheduler's shadow of LED state; 1 after a forwarded start, 0 after a forwarded stop.

## Operation
- States: IDLE, ISSUE, HOLD.
- IDLE, any `req` high: pick the winner round-robin, latch the winner index and its `req_cmd`, then go to ISSUE.
- IDLE, no request: stay in IDLE.
- Round-robin: priority starts at index `ptr`. After granting index i, `ptr` = (i+1) mod N_REQ. Reset `ptr` = 0.
- ISSUE, exactly one cycle:
  - `gnt[winner]`=1.
  - If the latched command differs from `led_on`: `write`=1, `cmd`=latched command, `led_on` updates at the end of the cycle. Next state is HOLD, or IDLE if HOLD_CYCLES=0.
  - If the latched command equals `led_on` (redundant): `gnt` still pulses, `write`=0, next state IDLE, no hold.
- HOLD: counter loads HOLD_CYCLES on entry and decrements each cycle. Go to IDLE on the cycle the counter reaches 1. Requests are sampled but not granted.
- Counter width is $clog2(HOLD_CYCLES+1). No wrap; the counter saturates at 0.
- A requester drops `req` in the cycle after seeing `gnt`. A `req` still high in the first IDLE cycle is treated as a new request.

## Timing
- Reset values: `gnt`=0, `write`=0, `cmd`=0, `busy`=0, `led_on`=0, state IDLE, `ptr`=0, counters 0. All apply immediately on `reset` assertion.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Latency, `req` rising in IDLE at edge k: `gnt`/`write` are high in cycle k+1. The next grant is possible no earlier than cycle k+2+HOLD_CYCLES.
- Simultaneous requests: exactly one grant per ISSUE; the others wait. No requester waits more than N_REQ grants.
- `req` dropped before grant: ignored if it is low when sampled in IDLE.
- Reset mid-ISSUE or mid-HOLD: the pulse is truncated and the state is abandoned. The LED controller shares `reset`, so `led_on`=0 stays consistent with it.

## Configuration
- `LED_SCHED_TIMEOUT_EN` defined:
  - A cycle counter runs while `led_on`=1 and clears on any forwarded stop or on reset.
  - When the counter reaches TIMEOUT_CYCLES, an internal stop is pending.
  - The pending stop is issued in the next IDLE cycle ahead of all requesters: ISSUE with `write`=1, `cmd`=0, `gnt`=0, `ptr` unchanged. HOLD follows as normal.
- `LED_SCHED_TIMEOUT_EN` not defined: no timeout logic. The LED stays on until a requester stops it.

## Test plan
- Reset, then `req[0]`=1, `req_cmd[0]`=1 -> next cycle `gnt`=0001, `write`=1, `cmd`=1; `led_on`=1 after; `busy` high 1+8 cycles.
- `led_on`=1, `req[2]` start -> `gnt`=0100, `write`=0, back in IDLE next cycle, `busy` high 1 cycle.
- `req`=1111 all stop with `led_on`=1, each dropping `req` after its grant -> grants in order 0001, 0010, 0100, 1000. Only the first has `write`=1; hold is applied only after the first.
- HOLD_CYCLES=0, alternating start/stop from `req[1]` -> `write` pulses every 2 cycles with `cmd` 1,0,1,...
- `reset` pulsed during HOLD after a start -> all outputs 0 immediately; first request after release is granted with 1-cycle latency.
- With `LED_SCHED_TIMEOUT_EN`, TIMEOUT_CYCLES=20: start, no further requests -> internal stop `write`=1, `cmd`=0, `gnt`=0 issued 21 cycles after the start's `led_on` rise.
